temp_sens_ctrl: RTL and testbench
=================================

TEMP_SENS_CTRL -- requirements
Module: temp_sens_ctrl

Interface
REQ-001 The block SHALL have parameter CFG_CMD, default 16'h0160, meaning the 2-byte configuration word written once after reset.
REQ-002 The block SHALL have parameter RD_CMD, default 16'h0000, meaning the 2-byte read-address word sent before each temperature read.
REQ-003 The block SHALL have parameter PERIOD, default 16'd1000, meaning the number of sck_in cycles between periodic reads (0 disables periodic reads).
REQ-004 The block SHALL have parameter TIMEOUT, default 8'd100, meaning the maximum number of sck_in cycles spent waiting for spi_trans_done.
REQ-005 The block SHALL have port sck_in, input, 1 bit: the single clock, shared with the spi block.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit: periodic reads permitted.
REQ-008 The block SHALL have port trig, input, 1 bit: single-cycle one-shot read request.
REQ-009 The block SHALL have port err_clr, input, 1 bit: clears err_timeout.
REQ-010 The block SHALL have port spi_tx_data, output, 16 bits, driven to the spi in_bytes input.
REQ-011 The block SHALL have port spi_tx_cnt, output, 2 bits, driven to the spi out_bytes_count input.
REQ-012 The block SHALL have port spi_rx_cnt, output, 2 bits, driven to the spi in_bytes_count input.
REQ-013 The block SHALL have port spi_start, output, 1 bit, driven to the spi start_trans input.
REQ-014 The block SHALL have port spi_rx_data, input, 32 bits, driven from the spi out_bytes output.
REQ-015 The block SHALL have port spi_trans_done, input, 1 bit, a level driven from the spi trans_done output.
REQ-016 The block SHALL have port temp, output, 16 bits: the last captured reading.
REQ-017 The block SHALL have ports temp_valid (output, 1 bit, one-cycle pulse), busy (output, 1 bit) and err_timeout (output, 1 bit, sticky).

Function
REQ-018 The FSM SHALL have the states CFG_REQ, CFG_REL, IDLE, RD_REQ, CAPTURE and RD_REL.
REQ-019 On leaving reset the FSM SHALL enter CFG_REQ, driving spi_tx_data=CFG_CMD, spi_tx_cnt=2, spi_rx_cnt=0 and spi_start=1.
REQ-020 In CFG_REQ or RD_REQ, when spi_trans_done=1 is sampled, spi_start SHALL go to 0 on the next cycle and the FSM SHALL advance (CFG_REQ to CFG_REL; RD_REQ to CAPTURE).
REQ-021 In CFG_REL or RD_REL the FSM SHALL wait for spi_trans_done=0, then enter IDLE on the next cycle; no new spi_start SHALL be issued while spi_trans_done=1.
REQ-022 In IDLE with enable=1 and PERIOD!=0, a 16-bit period counter SHALL increment each cycle and request a read when it reaches PERIOD-1.
REQ-023 The period counter SHALL be cleared on entry to RD_REQ.
REQ-024 The period counter SHALL hold while enable=0.
REQ-025 A trig pulse SHALL set a one-deep pending flag regardless of state; additional pulses while the flag is set SHALL be dropped.
REQ-026 In IDLE, a pending trig or a period request SHALL move the FSM to RD_REQ on the next cycle and clear the flag; spi_start=1 SHALL appear one cycle after trig is sampled in IDLE.
REQ-027 In RD_REQ the block SHALL drive spi_tx_data=RD_CMD, spi_tx_cnt=2 and spi_rx_cnt=2.
REQ-028 In CAPTURE (one cycle), temp SHALL load spi_rx_data[15:0], temp_valid SHALL pulse high for exactly that cycle, and the FSM SHALL then enter RD_REL.
REQ-029 An 8-bit timeout counter SHALL run in CFG_REQ and RD_REQ; when it reaches TIMEOUT without spi_trans_done, spi_start SHALL drop, err_timeout SHALL set, temp SHALL be unchanged, no temp_valid SHALL be produced, and the FSM SHALL enter the matching REL state.
REQ-030 err_timeout SHALL remain set until err_clr=1; if err_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 enable dropping mid-read SHALL NOT abort the read.
REQ-033 If a period request and a pending trig coincide, the block SHALL perform one read and clear both.
REQ-034 spi_tx_data, spi_tx_cnt and spi_rx_cnt SHALL be registered and stable for the whole time spi_start=1.

Reset
REQ-035 While rst_n=0 the block SHALL immediately drive: spi_start=0, spi_tx_data=0, spi_tx_cnt=0, spi_rx_cnt=0, temp=0, temp_valid=0, busy=1, err_timeout=0, counters=0, pending flag=0, state=CFG_REQ (with outputs held as listed).
REQ-036 An assertion of rst_n mid-transaction SHALL abort it, and the configuration write SHALL be reissued after release.

Verification
REQ-037 Reset release with a spi model answering after 36 cycles SHALL produce one write with spi_tx_data=CFG_CMD, spi_tx_cnt=2 and spi_rx_cnt=0, followed by busy=0.
REQ-038 trig in IDLE with the model returning 32'h0000_1A2B SHALL produce spi_start one cycle later, then temp=16'h1A2B with one temp_valid pulse.
REQ-039 enable=1 with PERIOD=50 over 500 cycles SHALL produce reads starting 50 cycles plus transaction length apart, with no trig required.
REQ-040 If the model never asserts done, spi_start SHALL fall after 100 cycles, err_timeout=1 SHALL hold until err_clr, and temp SHALL be unchanged.
REQ-041 Three trig pulses during a read SHALL result in exactly one further read.
REQ-042 rst_n low mid-RD_REQ SHALL drive spi_start=0 immediately, and CFG_CMD SHALL be resent after release.

Source files
------------

// File: rtl/temp_sens_ctrl.sv
// Temperature sensor sequencer: issues the configuration write after reset, then runs
// periodic or triggered 2-byte reads through an external SPI engine and captures the result.
module temp_sens_ctrl #(
  parameter logic [15:0] CFG_CMD = 16'h0160,
  parameter logic [15:0] RD_CMD  = 16'h0000,
  parameter logic [15:0] PERIOD  = 16'd1000,
  parameter logic [7:0]  TIMEOUT = 8'd100
) (
  input  logic        sck_in,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        trig,
  input  logic        err_clr,
  output logic [15:0] spi_tx_data,
  output logic [1:0]  spi_tx_cnt,
  output logic [1:0]  spi_rx_cnt,
  output logic        spi_start,
  input  logic [31:0] spi_rx_data,
  input  logic        spi_trans_done,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    CFG_REQ,
    CFG_REL,
    IDLE,
    RD_REQ,
    CAPTURE,
    RD_REL
  } state_e;

  localparam logic [15:0] PER_LAST = PERIOD - 16'd1;

  state_e      state_q, state_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        pend_q, pend_d;
  logic        start_q, start_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic [1:0]  tx_cnt_q, tx_cnt_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [15:0] temp_q, temp_d;
  logic        tv_q, tv_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        err_set;
  logic        per_hit;
  logic        to_hit;
  logic        rx_hi_unused;

  assign rx_hi_unused = ^spi_rx_data[31:16];

  assign per_hit = (state_q == IDLE) && enable && (PERIOD != 16'd0) && (per_cnt_q == PER_LAST);
  assign to_hit  = (({1'b0, to_cnt_q} + 9'd1) >= {1'b0, TIMEOUT});

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    to_cnt_d  = to_cnt_q;
    pend_d    = pend_q;
    start_d   = start_q;
    tx_data_d = tx_data_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    temp_d    = temp_q;
    tv_d      = 1'b0;
    err_set   = 1'b0;

    if (trig) begin
      pend_d = 1'b1;
    end

    case (state_q)
      CFG_REQ: begin
        // start_q low here only on the first cycle out of reset: launch the config write
        if (!start_q) begin
          start_d   = 1'b1;
          tx_data_d = CFG_CMD;
          tx_cnt_d  = 2'd2;
          rx_cnt_d  = 2'd0;
          to_cnt_d  = '0;
        end else if (spi_trans_done) begin
          start_d = 1'b0;
          state_d = CFG_REL;
        end else if (to_hit) begin
          start_d = 1'b0;
          err_set = 1'b1;
          state_d = CFG_REL;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end

      CFG_REL, RD_REL: begin
        if (!spi_trans_done) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        // a pending or same-cycle trig and a period hit collapse into one read
        if (pend_q || trig || per_hit) begin
          state_d   = RD_REQ;
          start_d   = 1'b1;
          tx_data_d = RD_CMD;
          tx_cnt_d  = 2'd2;
          rx_cnt_d  = 2'd2;
          to_cnt_d  = '0;
          per_cnt_d = '0;
          pend_d    = 1'b0;
        end else if (enable && (PERIOD != 16'd0)) begin
          per_cnt_d = per_cnt_q + 16'd1;
        end
      end

      RD_REQ: begin
        if (spi_trans_done) begin
          start_d = 1'b0;
          temp_d  = spi_rx_data[15:0];
          tv_d    = 1'b1;
          state_d = CAPTURE;
        end else if (to_hit) begin
          start_d = 1'b0;
          err_set = 1'b1;
          state_d = RD_REL;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end

      CAPTURE: begin
        state_d = RD_REL;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sck_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CFG_REQ;
      per_cnt_q <= '0;
      to_cnt_q  <= '0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      tx_data_q <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      temp_q    <= '0;
      tv_q      <= 1'b0;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      to_cnt_q  <= to_cnt_d;
      pend_q    <= pend_d;
      start_q   <= start_d;
      tx_data_q <= tx_data_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      temp_q    <= temp_d;
      tv_q      <= tv_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign spi_start   = start_q;
  assign spi_tx_data = tx_data_q;
  assign spi_tx_cnt  = tx_cnt_q;
  assign spi_rx_cnt  = rx_cnt_q;
  assign temp        = temp_q;
  assign temp_valid  = tv_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_temp_sens_ctrl.sv
// Directed bench for temp_sens_ctrl with a behavioural SPI responder
// (done asserted a fixed number of cycles after spi_start, held until spi_start falls).
module tb_temp_sens_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] spi_tx_data;
  logic [1:0]  spi_tx_cnt;
  logic [1:0]  spi_rx_cnt;
  logic        spi_start;
  logic [31:0] spi_rx_data = '0;
  logic        spi_trans_done = 1'b0;
  logic [15:0] temp;
  logic        temp_valid;
  logic        busy;
  logic        err_timeout;

  always #5 clk = ~clk;

  temp_sens_ctrl #(
    .CFG_CMD(16'h0160),
    .RD_CMD (16'h0000),
    .PERIOD (16'd50),
    .TIMEOUT(8'd100)
  ) dut (
    .sck_in        (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .trig          (trig),
    .err_clr       (err_clr),
    .spi_tx_data   (spi_tx_data),
    .spi_tx_cnt    (spi_tx_cnt),
    .spi_rx_cnt    (spi_rx_cnt),
    .spi_start     (spi_start),
    .spi_rx_data   (spi_rx_data),
    .spi_trans_done(spi_trans_done),
    .temp          (temp),
    .temp_valid    (temp_valid),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // responder and monitor state
  int          m_lat = 36;
  bit          m_never = 1'b0;
  logic [31:0] m_data = '0;
  int          m_cnt = 0;
  logic        prev_start = 1'b0;
  int          tx_n = 0;
  int          tv_n = 0;
  logic [15:0] tv_temp = '0;
  int          start_t [32];
  logic [15:0] log_data [32];
  logic [1:0]  log_tx [32];
  logic [1:0]  log_rx [32];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      spi_trans_done = 1'b0;
      m_cnt = 0;
      prev_start = 1'b0;
    end else begin
      if (spi_start && !prev_start) begin
        if (tx_n < 32) begin
          start_t[tx_n]  = cyc;
          log_data[tx_n] = spi_tx_data;
          log_tx[tx_n]   = spi_tx_cnt;
          log_rx[tx_n]   = spi_rx_cnt;
        end
        tx_n++;
      end
      prev_start = spi_start;
      if (temp_valid) begin
        tv_n++;
        tv_temp = temp;
      end
      if (spi_trans_done) begin
        if (!spi_start) spi_trans_done = 1'b0;
      end else if (spi_start && !m_never) begin
        m_cnt++;
        if (m_cnt == m_lat) begin
          spi_trans_done = 1'b1;
          spi_rx_data = m_data;
          m_cnt = 0;
        end
      end else if (!spi_start) begin
        m_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int n0;
    int tv0;
    int c0;

    // reset values, checked while reset is held
    #1 rst_n = 1'b0;
    #3;
    chk("rst_start",   {31'd0, spi_start},   32'd0);
    chk("rst_txdata",  {16'd0, spi_tx_data}, 32'd0);
    chk("rst_txcnt",   {30'd0, spi_tx_cnt},  32'd0);
    chk("rst_rxcnt",   {30'd0, spi_rx_cnt},  32'd0);
    chk("rst_temp",    {16'd0, temp},        32'd0);
    chk("rst_tv",      {31'd0, temp_valid},  32'd0);
    chk("rst_busy",    {31'd0, busy},        32'd1);
    chk("rst_err",     {31'd0, err_timeout}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // configuration write on release
    step();
    chk("cfg_start",  {31'd0, spi_start},   32'd1);
    chk("cfg_txdata", {16'd0, spi_tx_data}, 32'h0160);
    chk("cfg_txcnt",  {30'd0, spi_tx_cnt},  32'd2);
    chk("cfg_rxcnt",  {30'd0, spi_rx_cnt},  32'd0);
    chk("cfg_busy",   {31'd0, busy},        32'd1);
    wait_idle(100, "cfg_idle");
    chk("cfg_writes", tx_n, 32'd1);
    chk("cfg_log_data", {16'd0, log_data[0]}, 32'h0160);
    chk("cfg_log_tx",   {30'd0, log_tx[0]},   32'd2);
    chk("cfg_log_rx",   {30'd0, log_rx[0]},   32'd0);

    // one-shot trig read
    m_data = 32'h0000_1A2B;
    tv0 = tv_n;
    chk("idle_start", {31'd0, spi_start}, 32'd0);
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("trig_start",  {31'd0, spi_start},   32'd1);
    chk("trig_txdata", {16'd0, spi_tx_data}, 32'h0000);
    chk("trig_txcnt",  {30'd0, spi_tx_cnt},  32'd2);
    chk("trig_rxcnt",  {30'd0, spi_rx_cnt},  32'd2);
    chk("trig_busy",   {31'd0, busy},        32'd1);
    wait_idle(100, "trig_idle");
    chk("trig_temp",    {16'd0, temp},    32'h1A2B);
    chk("trig_tv_temp", {16'd0, tv_temp}, 32'h1A2B);
    chk("trig_tv",      tv_n - tv0,       32'd1);
    chk("trig_reads",   tx_n,             32'd2);

    // three trig pulses during a read give exactly one further read
    m_data = 32'hFFFF_5555;
    n0 = tx_n;
    tv0 = tv_n;
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (3) step();
    repeat (3) begin
      trig = 1'b1;
      step();
      trig = 1'b0;
      step();
    end
    repeat (150) step();
    chk("multi_reads", tx_n - n0, 32'd2);
    chk("multi_tv",    tv_n - tv0, 32'd2);
    chk("multi_temp",  {16'd0, temp}, 32'h5555);
    chk("multi_busy",  {31'd0, busy}, 32'd0);

    // timeout: responder never answers
    m_never = 1'b1;
    tv0 = tv_n;
    trig = 1'b1;
    step();
    trig = 1'b0;
    n = 0;
    while (spi_start === 1'b1 && n < 300) begin
      n++;
      step();
    end
    chk("to_len",  n, 32'd100);
    chk("to_err",  {31'd0, err_timeout}, 32'd1);
    chk("to_temp", {16'd0, temp}, 32'h5555);
    repeat (20) step();
    chk("to_err_hold", {31'd0, err_timeout}, 32'd1);
    chk("to_tv",       tv_n - tv0, 32'd0);
    chk("to_busy",     {31'd0, busy}, 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", {31'd0, err_timeout}, 32'd0);
    m_never = 1'b0;

    // periodic reads: 50 idle cycles + 38-cycle transaction
    m_data = 32'h0000_0C3A;
    enable = 1'b1;
    n0 = tx_n;
    c0 = cyc;
    repeat (500) step();
    chk("per_reads", tx_n - n0, 32'd6);
    chk("per_first", start_t[n0] - c0, 32'd50);
    chk("per_int1",  start_t[n0 + 1] - start_t[n0], 32'd88);
    chk("per_int2",  start_t[n0 + 2] - start_t[n0 + 1], 32'd88);
    chk("per_int3",  start_t[n0 + 3] - start_t[n0 + 2], 32'd88);
    chk("per_temp",  {16'd0, temp}, 32'h0C3A);

    // dropping enable mid-read completes the read, then no further reads
    n = 0;
    while (spi_start !== 1'b1 && n < 200) begin
      n++;
      step();
    end
    enable = 1'b0;
    tv0 = tv_n;
    wait_idle(100, "en_drop_idle");
    chk("en_drop_tv", tv_n - tv0, 32'd1);
    n0 = tx_n;
    repeat (150) step();
    chk("en_hold", tx_n - n0, 32'd0);

    // reset in the middle of a read
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (5) step();
    chk("rmid_pre", {31'd0, spi_start}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid_start", {31'd0, spi_start}, 32'd0);
    chk("rmid_busy",  {31'd0, busy},      32'd1);
    chk("rmid_data",  {16'd0, spi_tx_data}, 32'd0);
    n0 = tx_n;
    step();
    rst_n = 1'b1;
    step();
    chk("rmid_cfg_start", {31'd0, spi_start},   32'd1);
    chk("rmid_cfg_data",  {16'd0, spi_tx_data}, 32'h0160);
    chk("rmid_cfg_rxcnt", {30'd0, spi_rx_cnt},  32'd0);
    wait_idle(100, "rmid_idle");
    chk("rmid_cfg_log", {16'd0, log_data[n0]}, 32'h0160);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
